// File: rtl/m_dmx_stream.sv
// m_dmx_stream: registered 1-to-N packet demultiplexer with valid/ready.
// The destination is latched on the first beat of each packet. Packets that
// name a non-existent port are swallowed and counted in drop_cnt.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for the first beat of a packet
//   PKT    | mid-packet, beats routed to the latched sel_q
//   DROP   | mid-packet with illegal select, beats discarded
module m_dmx_stream #(
  parameter int DW = 32,
  parameter int N  = 4,
  parameter int SW = $clog2(N),
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic [SW-1:0] in_sel,
  output logic [N-1:0]  out_valid,
  input  logic [N-1:0]  out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [CW-1:0] drop_cnt,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PKT,
    S_DROP
  } state_t;

  // One extra bit so the compare still works when N is a power of two.
  localparam logic [SW:0] NUM_PORTS = (SW + 1)'(N);

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] dest_q, dest_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          vld_q, vld_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic drain;
  logic hs;
  logic sel_ok;
  logic load;
  logic drop_first;

  // Handshake qualifiers; DROP never waits on the output side.
  always_comb begin
    drain      = vld_q && out_ready[dest_q];
    in_ready   = (state_q == S_DROP) ? 1'b1 : (!vld_q || drain);
    hs         = in_valid && in_ready;
    sel_ok     = ({1'b0, in_sel} < NUM_PORTS);
    load       = hs && ((state_q == S_PKT) || ((state_q == S_IDLE) && sel_ok));
    drop_first = hs && (state_q == S_IDLE) && !sel_ok;
  end

  // Next-state for the packet FSM, output register and drop counter.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    dest_d     = dest_q;
    data_d     = data_q;
    last_d     = last_q;
    vld_d      = vld_q;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (sel_ok) begin
            sel_d = in_sel;
            if (!in_last) state_d = S_PKT;
          end else if (!in_last) begin
            state_d = S_DROP;
          end
        end
      end
      S_PKT, S_DROP: begin
        if (hs && in_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      data_d = in_data;
      last_d = in_last;
      dest_d = (state_q == S_PKT) ? sel_q : in_sel;
      vld_d  = 1'b1;
    end else if (drain) begin
      vld_d = 1'b0;
    end

    if (drop_first && (drop_cnt_q != {CW{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      dest_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      vld_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
      last_q     <= last_d;
      vld_q      <= vld_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // One-hot port valid decoded from the held destination.
  always_comb begin
    out_valid = '0;
    for (int i = 0; i < N; i++) begin
      out_valid[i] = vld_q && (dest_q == SW'(i));
    end
    out_data = data_q;
    out_last = last_q;
    drop_cnt = drop_cnt_q;
    busy     = (state_q != S_IDLE) || vld_q;
  end

endmodule

// File: tb/tb_m_dmx_stream.sv
// Directed bench for m_dmx_stream. N=5 leaves selects 5..7 illegal, and
// CW=2 makes the drop counter saturate at 3.
module tb_m_dmx_stream;

  localparam int DW = 32;
  localparam int N  = 5;
  localparam int SW = $clog2(N);
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [SW-1:0] in_sel;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] drop_cnt;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  m_dmx_stream #(.DW(DW), .N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a beat, check it is accepted, clock it, check the output port.
  task automatic beat(input string tag, input logic [DW-1:0] d, input logic l,
                      input logic [SW-1:0] s, input logic [N-1:0] exp_vld);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_sel   = s;
    #1;
    chk({tag, ".rdy"}, in_ready, 1'b1);
    step();
    chk({tag, ".vld"}, out_valid, exp_vld);
    if (exp_vld != '0) begin
      chk({tag, ".data"}, out_data, d);
      chk({tag, ".last"}, out_last, l);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_sel    = '0;
    out_ready = '1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst.vld",   out_valid, '0);
    chk("rst.data",  out_data,  '0);
    chk("rst.last",  out_last,  1'b0);
    chk("rst.drop",  drop_cnt,  '0);
    chk("rst.busy",  busy,      1'b0);
    chk("rst.rdy",   in_ready,  1'b1);

    // 3-beat packet to port 2
    beat("p2b0", 32'hA0, 1'b0, 3'd2, 5'b00100);
    chk("p2b0.busy", busy, 1'b1);
    beat("p2b1", 32'hA1, 1'b0, 3'd2, 5'b00100);
    beat("p2b2", 32'hA2, 1'b1, 3'd2, 5'b00100);
    idle();
    chk("p2.end.vld",  out_valid, '0);
    chk("p2.end.hold", out_data,  32'hA2);
    chk("p2.end.busy", busy,      1'b0);

    // back-to-back packets to different ports, no bubble
    beat("b2b.p1",  32'h11, 1'b1, 3'd1, 5'b00010);
    beat("b2b.p3a", 32'h30, 1'b0, 3'd3, 5'b01000);
    beat("b2b.p3b", 32'h31, 1'b1, 3'd0, 5'b01000);
    idle();

    // backpressure on port 0, other readies have no effect
    out_ready = 5'b11110;
    beat("bp.b0", 32'h50, 1'b0, 3'd0, 5'b00001);
    in_valid = 1'b1;
    in_data  = 32'h51;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.stall.rdy",  in_ready,  1'b0);
      chk("bp.stall.data", out_data,  32'h50);
      chk("bp.stall.vld",  out_valid, 5'b00001);
      step();
    end
    out_ready = '1;
    beat("bp.b1", 32'h51, 1'b0, 3'd4, 5'b00001);
    beat("bp.b2", 32'h52, 1'b1, 3'd4, 5'b00001);
    idle();

    // select changes mid-packet are ignored
    beat("ms.b0", 32'h60, 1'b0, 3'd1, 5'b00010);
    beat("ms.b1", 32'h61, 1'b0, 3'd3, 5'b00010);
    beat("ms.b2", 32'h62, 1'b0, 3'd3, 5'b00010);
    beat("ms.b3", 32'h63, 1'b1, 3'd3, 5'b00010);
    idle();

    // illegal select: whole packet dropped, counted once; outputs not ready
    out_ready = '0;
    beat("dr.b0", 32'hD0, 1'b0, 3'd5, 5'b00000);
    chk("dr.b0.cnt",  drop_cnt, 2'd1);
    chk("dr.b0.busy", busy,     1'b1);
    beat("dr.b1", 32'hD1, 1'b0, 3'd2, 5'b00000);
    beat("dr.b2", 32'hD2, 1'b1, 3'd2, 5'b00000);
    chk("dr.cnt", drop_cnt, 2'd1);
    out_ready = '1;
    idle();
    chk("dr.idle.busy", busy, 1'b0);
    beat("dr.next", 32'h70, 1'b1, 3'd4, 5'b10000);
    idle();

    // saturation of the 2-bit counter
    beat("sat0", 32'hE0, 1'b1, 3'd6, 5'b00000);
    chk("sat0.cnt", drop_cnt, 2'd2);
    beat("sat1", 32'hE1, 1'b1, 3'd7, 5'b00000);
    chk("sat1.cnt", drop_cnt, 2'd3);
    beat("sat2", 32'hE2, 1'b1, 3'd5, 5'b00000);
    beat("sat3", 32'hE3, 1'b1, 3'd7, 5'b00000);
    chk("sat.cnt", drop_cnt, 2'd3);

    // reset mid-packet with a held beat
    out_ready = '0;
    beat("rp.b0", 32'h80, 1'b0, 3'd2, 5'b00100);
    chk("rp.busy", busy, 1'b1);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    chk("rp.vld",  out_valid, '0);
    chk("rp.drop", drop_cnt,  '0);
    chk("rp.busy", busy,      1'b0);
    chk("rp.rdy",  in_ready,  1'b1);
    out_ready = '1;
    beat("rp.next", 32'h90, 1'b1, 3'd0, 5'b00001);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
